stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that shares one valid/ready output stream between `NREQ` upstream valid/ready streams. Each accepted beat passes through a two-entry skid stage (main + skid register) so the output is fully registered and sustains one beat per cycle under back-pressure. Sits in front of a shared pipeline consumer, tagging every beat with its source index.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `DWIDTH`, 8: data width per beat.
- `IDW`, `$clog2(NREQ)`: source-index width, derived, not overridden.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `i_data`  in  NREQ*DWIDTH  requester data; requester k at bits [k*DWIDTH +: DWIDTH].
- `i_valid`  in  NREQ  per-requester beat valid.
- `i_last`  in  NREQ  per-requester last-beat-of-packet flag.
- `o_ready`  out  NREQ  per-requester ready; at most one bit set (one-hot or zero).
- `o_data`  out  DWIDTH  output data.
- `o_last`  out  1  output last flag.
- `o_id`  out  IDW  index of the requester that produced `o_data`.
- `o_valid`  out  1  output valid.
- `i_ready`  in  1  downstream ready.

## Operation
- Beat transfer upstream: `i_valid[k] && o_ready[k]`. Downstream: `o_valid && i_ready`.
- Round-robin pointer `ptr` (IDW bits, reset 0): search starts at `ptr` and wraps modulo `NREQ`; first index with `i_valid` set wins (`gnt`). No valid requester: `o_ready` = 0.
- On every accepted beat from winner w (non-lock mode) or on its accepted `i_last` beat (lock mode): `ptr` <= (w+1) mod NREQ. Wrap: w = NREQ-1 gives `ptr` = 0, including non-power-of-2 `NREQ`.
- `o_ready[gnt]` = 1 only when the skid register is empty; other bits 0.
- Skid stage: accepted beat loads main register if main is empty or drains this cycle, else the skid register. When main drains and skid is full, skid moves to main in the same cycle. Skid full forces all `o_ready` to 0. No beat is ever dropped or duplicated.
- `{o_data, o_last, o_id}` = main register; `o_valid` = main full. Output stays stable while `o_valid && !i_ready`.
- FSM (lock mode only): ARB selects `gnt` combinationally from `i_valid`. An accepted beat with `i_last` = 0 moves to LOCK and registers `gnt`. LOCK keeps `gnt` fixed regardless of other requesters and of the locked requester's `i_valid` dropping. An accepted beat with `i_last` = 1 returns to ARB. Both events in one cycle (single-beat packet): stay in ARB.

## Timing
- Reset (`rstn` = 0 at an edge): `o_valid` = 0, `o_data` = 0, `o_last` = 0, `o_id` = 0, `o_ready` = 0 while `rstn` is low, `ptr` = 0, FSM = ARB, both registers empty.
- Reset mid-packet or mid-stall discards buffered beats and lock state. Upstream is responsible for re-sending.
- Latency: beat accepted at edge N appears on `o_valid` after edge N (one cycle) when main is empty.
- Throughput: 1 beat/cycle with `i_ready` held high. Switching between requesters costs no bubble.
- `o_ready` is combinational from `i_valid`, FSM state and skid occupancy. No combinational path from `i_ready` to `o_ready`; skid occupancy is registered.
- After `i_ready` falls with main full, at most one more beat is accepted (into skid). `o_ready` deasserts the next cycle.

## Configuration
- `STREAM_ARB_LOCK_EN` defined: packet lock mode. The grant is held from the first beat through the beat with `i_last` = 1, and `ptr` advances only on a `last` beat. Packets from different requesters never interleave.
- Not defined: arbitration per beat, and `ptr` advances after every accepted beat. The FSM is not built and `i_last` is only forwarded to `o_last`.

## Test plan
- Reset: hold `rstn` = 0 for 3 cycles with all `i_valid` = 1 -> `o_valid` = 0, `o_ready` = 4'b0000. The first release cycle grants requester 0 (`o_ready` = 4'b0001).
- Fairness: all four `i_valid` high, `i_last` = 1, `i_ready` = 1 -> `o_id` sequence 0,1,2,3,0,... and one beat per cycle after 1-cycle latency.
- Back-pressure: stream data 0x10..0x1F from requester 2 and toggle `i_ready` randomly -> output is exactly 0x10..0x1F in order, no loss or duplicates. `o_ready` is low whenever skid is full.
- Lock (macro on): requester 1 sends 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2) while requester 0 is valid -> `o_id` = 1,1,1 then 0. Requester 1 dropping `i_valid` mid-packet for 2 cycles keeps `o_ready` = 4'b0010.
- Per-beat mode (macro off): same stimulus -> `o_id` interleaves 1,0,1,0,... (after the first beat from requester 1, `ptr` = 2 wraps to 0).
- Reset mid-stall: main and skid full, `i_ready` = 0, then `rstn` = 0 for 1 cycle -> `o_valid` = 0 next cycle and `ptr` = 0.

Source files
------------

// File: rtl/stream_arb_if.sv
// Valid/ready bundle between NREQ requesters, the round-robin arbiter and one downstream consumer.
// slave: arbiter side; master: environment side (requesters plus consumer).
interface stream_arb_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned IDW    = $clog2(NREQ)
);
    logic [NREQ*DWIDTH-1:0] i_data;
    logic [NREQ-1:0]        i_valid;
    logic [NREQ-1:0]        i_last;
    logic [NREQ-1:0]        o_ready;
    logic [DWIDTH-1:0]      o_data;
    logic                   o_last;
    logic [IDW-1:0]         o_id;
    logic                   o_valid;
    logic                   i_ready;

    modport slave (
        input  i_data, i_valid, i_last, i_ready,
        output o_ready, o_data, o_last, o_id, o_valid
    );

    modport master (
        output i_data, i_valid, i_last, i_ready,
        input  o_ready, o_data, o_last, o_id, o_valid
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NREQ valid/ready streams into one registered output via a main+skid stage.
// STREAM_ARB_LOCK_EN: hold the grant for a whole packet (through i_last) instead of re-arbitrating per beat.
module stream_rr_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DWIDTH = 8
) (
    input logic             clk,
    input logic             rstn,
    stream_arb_if.slave     bus
);
    localparam int unsigned IDW = $clog2(NREQ);

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              last;
        logic [IDW-1:0]    id;
    } beat_t;

    beat_t          main_q, main_d;
    beat_t          skid_q, skid_d;
    logic           main_vld_q, main_vld_d;
    logic           skid_vld_q, skid_vld_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [IDW-1:0] rr_gnt_c;
    logic           rr_vld_c;
    logic [IDW-1:0] gnt_c;
    logic           gnt_vld_c;
    logic [NREQ-1:0] ready_c;
    logic           accept_c;
    logic           drain_c;
    logic           adv_c;
    logic [IDW-1:0] ptr_next_c;
    beat_t          beat_c;

    // Search from ptr upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        int unsigned idx;
        rr_gnt_c = '0;
        rr_vld_c = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!rr_vld_c && bus.i_valid[IDW'(idx)]) begin
                rr_vld_c = 1'b1;
                rr_gnt_c = IDW'(idx);
            end
        end
    end

`ifdef STREAM_ARB_LOCK_EN
    typedef enum logic {ARB, LOCK} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;

    // While locked the grant ignores i_valid, so the owner may pause mid-packet.
    always_comb begin
        gnt_c     = rr_gnt_c;
        gnt_vld_c = rr_vld_c;
        if (state_q == LOCK) begin
            gnt_c     = lock_id_q;
            gnt_vld_c = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        adv_c     = accept_c && beat_c.last;
        if (accept_c) begin
            if (beat_c.last) begin
                state_d = ARB;
            end else begin
                state_d   = LOCK;
                lock_id_d = gnt_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ARB;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    always_comb begin
        gnt_c     = rr_gnt_c;
        gnt_vld_c = rr_vld_c;
        adv_c     = accept_c;
    end
`endif

    // Ready depends only on registered skid occupancy, never on i_ready.
    always_comb begin
        ready_c = '0;
        if (rstn && gnt_vld_c && !skid_vld_q) ready_c[gnt_c] = 1'b1;
    end

    assign bus.o_ready = ready_c;

    always_comb begin
        accept_c    = bus.i_valid[gnt_c] && ready_c[gnt_c];
        drain_c     = main_vld_q && bus.i_ready;
        beat_c.data = bus.i_data[32'(gnt_c) * DWIDTH +: DWIDTH];
        beat_c.last = bus.i_last[gnt_c];
        beat_c.id   = gnt_c;
        ptr_next_c  = (gnt_c == IDW'(NREQ - 1)) ? '0 : gnt_c + IDW'(1);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_c) ptr_d = ptr_next_c;
    end

    // Skid refills main on drain; accepts only happen while skid is empty.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (drain_c) main_vld_d = 1'b0;
        if (drain_c && skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
        end
        if (accept_c) begin
            if (!main_vld_q || drain_c) begin
                main_d     = beat_c;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = beat_c;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.o_data  = main_q.data;
    assign bus.o_last  = main_q.last;
    assign bus.o_id    = main_q.id;
    assign bus.o_valid = main_vld_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: reset, fairness, back-pressure, lock/per-beat arbitration, reset mid-stall.
// Expected sequences are hand-derived; the arbitration table follows STREAM_ARB_LOCK_EN.
module tb_stream_rr_arbiter;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned DWIDTH = 8;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stream_arb_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

    stream_rr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rstn        = 1'b0;
        bus.i_valid = '0;
        bus.i_last  = '0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        bus.i_valid = 4'hF;
        bus.i_last  = 4'hF;
        bus.i_data  = 32'h4433_2211;
        bus.i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (bus.o_valid !== 1'b0) begin
                bad++; $display("FAIL reset_o_valid cyc=%0d got=%b exp=0", c, bus.o_valid);
            end
            total++;
            if (bus.o_ready !== 4'b0000) begin
                bad++; $display("FAIL reset_o_ready cyc=%0d got=%b exp=0000", c, bus.o_ready);
            end
        end
        total++;
        if (bus.o_data !== 8'h00 || bus.o_id !== 2'd0 || bus.o_last !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got data=%h id=%0d last=%b exp 00/0/0", bus.o_data, bus.o_id, bus.o_last);
        end
        rstn = 1'b1;
        #1;
        total++;
        if (bus.o_ready !== 4'b0001) begin
            bad++; $display("FAIL reset_release_grant got=%b exp=0001", bus.o_ready);
        end
        bus.i_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 4; k++) bus.i_data[k*8 +: 8] = 8'h40 + 8'(k);
        bus.i_last  = 4'hF;
        bus.i_valid = 4'hF;
        bus.i_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            total++;
            if (bus.o_valid !== 1'b1 || bus.o_id !== 2'(n % 4) || bus.o_data !== 8'h40 + 8'(n % 4)) begin
                bad++;
                $display("FAIL fair_out n=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                         n, bus.o_valid, bus.o_id, bus.o_data, n % 4, 8'h40 + 8'(n % 4));
            end
            total++;
            if (bus.o_ready !== 4'(1 << ((n + 1) % 4))) begin
                bad++; $display("FAIL fair_ready n=%0d got=%b exp=%b", n, bus.o_ready, 4'(1 << ((n + 1) % 4)));
            end
        end
        bus.i_valid = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_pressure();
        logic [31:0] pat;
        logic [3:0]  exp_rdy;
        int          sent;
        int          got;
        int          occ;
        bit          acc;
        bit          dn;
        pat  = 32'hB271_CA69;
        sent = 0;
        got  = 0;
        occ  = 0;
        do_reset();
        for (int cyc = 0; cyc < 120 && got < 16; cyc++) begin
            total++;
            if (bus.o_valid !== (occ > 0)) begin
                bad++; $display("FAIL bp_o_valid cyc=%0d got=%b exp=%b", cyc, bus.o_valid, occ > 0);
            end
            bus.i_ready          = pat[cyc % 32];
            bus.i_valid          = (sent < 16) ? 4'b0100 : 4'b0000;
            bus.i_data[2*8 +: 8] = 8'h10 + 8'(sent);
            bus.i_last           = (sent == 15) ? 4'b0100 : 4'b0000;
            #1;
            exp_rdy = (sent < 16 && occ < 2) ? 4'b0100 : 4'b0000;
            total++;
            if (bus.o_ready !== exp_rdy) begin
                bad++; $display("FAIL bp_o_ready cyc=%0d occ=%0d got=%b exp=%b", cyc, occ, bus.o_ready, exp_rdy);
            end
            acc = bus.i_valid[2] && bus.o_ready[2];
            dn  = bus.o_valid && bus.i_ready;
            if (dn) begin
                total++;
                if (bus.o_data !== 8'h10 + 8'(got) || bus.o_id !== 2'd2 || bus.o_last !== (got == 15)) begin
                    bad++;
                    $display("FAIL bp_beat idx=%0d got d=%h id=%0d last=%b exp d=%h id=2 last=%b",
                             got, bus.o_data, bus.o_id, bus.o_last, 8'h10 + 8'(got), got == 15);
                end
            end
            @(posedge clk); #1;
            if (acc) sent++;
            if (dn) got++;
            occ = occ + int'(acc) - int'(dn);
        end
        total++;
        if (got != 16 || sent != 16) begin
            bad++; $display("FAIL bp_count got=%0d sent=%0d exp=16/16", got, sent);
        end
        bus.i_valid = '0;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_arbitration_mode();
`ifdef STREAM_ARB_LOCK_EN
        int v1_t [7] = '{1, 0, 0, 1, 1, 0, 0};
        int rdy_t[7] = '{2, 2, 2, 2, 2, 1, 1};
        int ov_t [7] = '{1, 0, 0, 1, 1, 1, 1};
        int id_t [7] = '{1, 0, 0, 1, 1, 0, 0};
        int dat_t[7] = '{'hA0, 0, 0, 'hA1, 'hA2, 'h05, 'h05};
`else
        int v1_t [7] = '{1, 1, 1, 1, 1, 0, 0};
        int rdy_t[7] = '{2, 1, 2, 1, 2, 1, 1};
        int ov_t [7] = '{1, 1, 1, 1, 1, 1, 1};
        int id_t [7] = '{1, 0, 1, 0, 1, 0, 0};
        int dat_t[7] = '{'hA0, 'h05, 'hA1, 'h05, 'hA2, 'h05, 'h05};
`endif
        int v0_t [7] = '{0, 1, 1, 1, 1, 1, 1};
        int r1;
        bit acc1;
        r1 = 0;
        do_reset();
        bus.i_ready          = 1'b1;
        bus.i_data[0*8 +: 8] = 8'h05;
        for (int c = 0; c < 7; c++) begin
            bus.i_valid[0]       = (v0_t[c] != 0);
            bus.i_valid[1]       = (v1_t[c] != 0) && (r1 < 3);
            bus.i_data[1*8 +: 8] = 8'hA0 + 8'(r1);
            bus.i_last           = {2'b00, (r1 == 2), 1'b1};
            #1;
            total++;
            if (bus.o_ready !== 4'(rdy_t[c])) begin
                bad++; $display("FAIL arb_ready c=%0d got=%b exp=%b", c, bus.o_ready, 4'(rdy_t[c]));
            end
            acc1 = bus.i_valid[1] && bus.o_ready[1];
            @(posedge clk); #1;
            if (acc1) r1++;
            total++;
            if (bus.o_valid !== (ov_t[c] != 0)) begin
                bad++; $display("FAIL arb_valid c=%0d got=%b exp=%0d", c, bus.o_valid, ov_t[c]);
            end
            if (ov_t[c] != 0) begin
                total++;
                if (bus.o_id !== 2'(id_t[c]) || bus.o_data !== 8'(dat_t[c])) begin
                    bad++;
                    $display("FAIL arb_beat c=%0d got id=%0d d=%h exp id=%0d d=%h",
                             c, bus.o_id, bus.o_data, id_t[c], 8'(dat_t[c]));
                end
            end
        end
        bus.i_valid = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        bus.i_ready          = 1'b0;
        bus.i_valid          = 4'b0010;
        bus.i_last           = 4'b0010;
        bus.i_data[1*8 +: 8] = 8'h77;
        #1;
        total++;
        if (bus.o_ready !== 4'b0010) begin
            bad++; $display("FAIL stall_ready_empty got=%b exp=0010", bus.o_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.o_valid !== 1'b1 || bus.o_ready !== 4'b0010) begin
            bad++; $display("FAIL stall_main_full got v=%b rdy=%b exp v=1 rdy=0010", bus.o_valid, bus.o_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h77 || bus.o_ready !== 4'b0000) begin
            bad++; $display("FAIL stall_skid_full got v=%b d=%h rdy=%b exp v=1 d=77 rdy=0000",
                            bus.o_valid, bus.o_data, bus.o_ready);
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 4'b0000) begin
            bad++; $display("FAIL stall_reset got v=%b rdy=%b exp v=0 rdy=0000", bus.o_valid, bus.o_ready);
        end
        rstn        = 1'b1;
        bus.i_valid = 4'hF;
        bus.i_last  = 4'hF;
        #1;
        total++;
        if (bus.o_ready !== 4'b0001) begin
            bad++; $display("FAIL stall_ptr_cleared got=%b exp=0001", bus.o_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.o_valid !== 1'b1 || bus.o_id !== 2'd0) begin
            bad++; $display("FAIL stall_after_reset got v=%b id=%0d exp v=1 id=0", bus.o_valid, bus.o_id);
        end
        bus.i_valid = '0;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_back_pressure();
        test_arbitration_mode();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
